// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Used by dmem_responder; DMEM_STATS_EN-independent.
package dmem_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int DMEM_WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_WAIT = S_WAIT,
      ST_RESP = S_RESP
   } state_t;

   typedef struct packed {
      logic                   we;
      logic [DMEM_WORD_W-1:0] addr;
      logic [DMEM_WORD_W-1:0] wdata;
   } dmem_req_t;

   // Misaligned or past the last full word of the array
   function automatic logic addr_bad(
      input logic [DMEM_WORD_W-1:0] addr,
      input int unsigned            mem_bytes
   );
      logic [DMEM_WORD_W-1:0] last;
      last = DMEM_WORD_W'(mem_bytes) - 32'd4;
      return (addr[1:0] != 2'b00) || (addr > last);
   endfunction

endpackage

// File: rtl/dmem_responder.sv
// Word load/store responder with fixed wait states over a byte array.
// Optional DMEM_STATS_EN adds saturating rd_count / wr_count outputs.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int LATENCY   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [DMEM_WORD_W-1:0] req_addr,
   input  logic [DMEM_WORD_W-1:0] req_wdata,
   output logic                   resp_valid,
   output logic [DMEM_WORD_W-1:0] resp_rdata,
   output logic                   resp_err
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0]            rd_count,
   output logic [15:0]            wr_count
`endif
);

   localparam int         AW       = $clog2(MEM_BYTES);
   localparam int         LM1      = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [3:0] CNT_LOAD = 4'(LM1);

   logic [7:0] mem_array [MEM_BYTES];

   state_t                 state;
   logic [3:0]             cnt;
   dmem_req_t              lat;
   dmem_req_t              cur;
   logic                   enter_resp;
   logic                   cur_err;
   logic                   do_wr;
   logic [AW-3:0]          wi;
   logic [DMEM_WORD_W-1:0] rd_word;

   // In IDLE the live request is used (zero-latency path), else the latched one
   always_comb begin
      cur = lat;
      if (state == ST_IDLE) begin
         cur = {req_we, req_addr, req_wdata};
      end
   end

   // Decode the edge that moves into RESP and the word it touches
   always_comb begin
      enter_resp = 1'b0;
      if (state == ST_IDLE) begin
         enter_resp = req_valid && (LATENCY == 0);
      end else if (state == ST_WAIT) begin
         enter_resp = (cnt == 4'd0);
      end
      cur_err = addr_bad(cur.addr, MEM_BYTES);
      do_wr   = enter_resp && cur.we && !cur_err;
      wi      = cur.addr[AW-1:2];
      rd_word = {mem_array[{wi, 2'd3}],
                 mem_array[{wi, 2'd2}],
                 mem_array[{wi, 2'd1}],
                 mem_array[{wi, 2'd0}]};
   end

   // Commit store bytes on the RESP entry edge; contents survive reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
      end else if (do_wr) begin
         mem_array[{wi, 2'd0}] <= cur.wdata[7:0];
         mem_array[{wi, 2'd1}] <= cur.wdata[15:8];
         mem_array[{wi, 2'd2}] <= cur.wdata[23:16];
         mem_array[{wi, 2'd3}] <= cur.wdata[31:24];
      end
   end

   // Control FSM with registered handshake and response outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat       <= cur;
                  req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     state <= ST_RESP;
                  end else begin
                     cnt   <= CNT_LOAD;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            resp_rdata <= (cur.we || cur_err) ? '0 : rd_word;
         end
      end
   end

`ifdef DMEM_STATS_EN
   // Count good loads and stores as they enter RESP, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (enter_resp && !cur_err) begin
         if (cur.we) begin
            if (wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
         end else begin
            if (rd_count != 16'hFFFF) begin
               rd_count <= rd_count + 16'd1;
            end
         end
      end
   end
`endif

endmodule
